// File: rtl/sevenseg_scan_driver_if.sv
// Bundles the load/digit inputs and the display pin outputs of sevenseg_scan_driver.
// The master side feeds values in, and the slave side (the driver) produces seg/an/frame_tick.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [7:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_tick;

    modport master (
        output load, digits, dp_in,
        input  seg, an, frame_tick
    );

    modport slave (
        input  load, digits, dp_in,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit hex 7-segment driver with frame-coherent double buffering.
// Optional feature: define SEVSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sevenseg_scan_driver_if.slave  bus
);
    localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ACW = CW + 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW  = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [ACW-1:0]        ACT_END  = ACW'(SCAN_DIV - BLANK_CYCLES);
    localparam logic [7:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [DW-1:0]         disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  commit;
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  active;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi]    = disp_dig_q[4*gi +: 4];
        assign onehot[gi] = (idx_q == IW'(gi));
    end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every digit to its left hold zero.
    always_comb begin
        logic run;
        lz_blank = '0;
        run      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run         = run && (nib[k] == 4'h0);
            lz_blank[k] = run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        commit   = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        pend_dig_d = bus.load ? bus.digits : pend_dig_q;
        pend_dp_d  = bus.load ? bus.dp_in  : pend_dp_q;

        // A load landing on the commit edge bypasses the pending buffer.
        disp_dig_d = disp_dig_q;
        disp_dp_d  = disp_dp_q;
        if (commit) begin
            disp_dig_d = bus.load ? bus.digits : pend_dig_q;
            disp_dp_d  = bus.load ? bus.dp_in  : pend_dp_q;
        end

        active  = ({1'b0, cnt_q} < ACT_END) && !lz_blank[idx_q];
        seg_raw = active ? {disp_dp_q[idx_q], hex_to_seg(nib[idx_q])} : 8'h00;
        an_raw  = active ? onehot : '0;

        seg_d  = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_d   = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
        tick_d = commit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver (4 digits, 8-cycle slots, 2 blank cycles, active-low pins).
// Expectations follow SEVSEG_LEADING_ZERO_BLANK_EN when the bench is built with that macro.
module tb_sevenseg_scan_driver;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [31:0] exp_seg;   // {slot3, slot2, slot1, slot0}
        logic [15:0] exp_an;    // {slot3, slot2, slot1, slot0}
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_tick && n < 64);
        chk({name, " frame_tick seen"}, {31'd0, bus.frame_tick}, 32'd1);
    endtask

    // Called on the negedge where frame_tick is high; samples cycle 0 of each slot.
    task automatic check_frame(input string name, input logic [31:0] eseg, input logic [15:0] ean);
        for (int k = 0; k < ND; k++) begin
            repeat ((k == 0) ? 1 : SD) @(negedge clk);
            chk($sformatf("%s seg slot%0d", name, k), {24'd0, bus.seg}, {24'd0, eseg[8*k +: 8]});
            chk($sformatf("%s an slot%0d", name, k), {28'd0, bus.an}, {28'd0, ean[4*k +: 4]});
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bus.load   = 1'b1;
        bus.digits = d;
        bus.dp_in  = p;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    initial begin
        logic [3:0] oh;
        int         idx;
        int         c;

        vecs[0] = '{16'h12AF, 4'b0000, 32'hF9A4888E, 16'h7BDE};
        vecs[1] = LZ ? '{16'h0030, 4'b0100, 32'hFFFFB0C0, 16'hFFDE}
                     : '{16'h0030, 4'b0100, 32'hC040B0C0, 16'h7BDE};
        vecs[2] = '{16'h89BC, 4'b1001, 32'h00908346, 16'h7BDE};
        vecs[3] = LZ ? '{16'h0000, 4'b0001, 32'hFFFFFF40, 16'hFFFE}
                     : '{16'h0000, 4'b0001, 32'hC0C0C040, 16'h7BDE};
        vecs[4] = '{16'h4567, 4'b0000, 32'h999282F8, 16'h7BDE};
        vecs[5] = '{16'hDE00, 4'b0000, 32'hA186C0C0, 16'h7BDE};

        bus.load   = 1'b0;
        bus.digits = '0;
        bus.dp_in  = '0;
        rst        = 1'b1;

        // Power-on reset state and first slot after release.
        repeat (3) @(negedge clk);
        chk("reset an", {28'd0, bus.an}, 32'hF);
        chk("reset seg", {24'd0, bus.seg}, 32'hFF);
        chk("reset frame_tick", {31'd0, bus.frame_tick}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset slot0 seg", {24'd0, bus.seg}, 32'hC0);
        chk("post-reset slot0 an", {28'd0, bus.an}, 32'hE);
        $display("seq reset-at-start done");

        // Asynchronous reset mid-run: outputs off at once, then restart at slot0.
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async reset an", {28'd0, bus.an}, 32'hF);
        chk("async reset seg", {24'd0, bus.seg}, 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("async release slot0 seg", {24'd0, bus.seg}, 32'hC0);
        chk("async release slot0 an", {28'd0, bus.an}, 32'hE);
        $display("seq async-reset mid-run done");

        // Slot timing and frame period over one whole frame.
        wait_tick("timing start");
        for (int n = 1; n <= ND * SD; n++) begin
            @(negedge clk);
            idx = (n - 1) / SD;
            c   = (n - 1) % SD;
            oh  = ~(4'b0001 << idx);
            if (c >= SD - BC || (LZ && idx != 0)) oh = 4'hF;
            chk($sformatf("timing an n=%0d", n), {28'd0, bus.an}, {28'd0, oh});
            chk($sformatf("timing tick n=%0d", n), {31'd0, bus.frame_tick}, {31'd0, n == ND * SD});
        end
        $display("seq timing frame done");

        // Table-driven vectors: load mid-frame, check the frame after the commit.
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].digits, vecs[i].dp);
            wait_tick($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp_seg, vecs[i].exp_an);
            $display("vec%0d digits=%h dp=%b checked", i, vecs[i].digits, vecs[i].dp);
        end

        // Mid-frame load stays hidden; a load on the commit cycle wins immediately.
        wait_tick("coherence start");
        repeat (10) @(negedge clk);
        do_load(16'h4567, 4'b0000);
        repeat (6) @(negedge clk);
        chk("no tear slot2 seg", {24'd0, bus.seg}, 32'h86);
        repeat (8) @(negedge clk);
        chk("no tear slot3 seg", {24'd0, bus.seg}, 32'hA1);
        repeat (6) @(negedge clk);
        do_load(16'h12AF, 4'b0000);
        chk("commit-cycle tick", {31'd0, bus.frame_tick}, 32'd1);
        @(negedge clk);
        chk("forwarded slot0 seg", {24'd0, bus.seg}, 32'h8E);
        chk("forwarded slot0 an", {28'd0, bus.an}, 32'hE);
        repeat (8) @(negedge clk);
        chk("forwarded slot1 seg", {24'd0, bus.seg}, 32'h88);
        $display("seq mid-frame and commit-cycle load done");

        // Reset in slot2 with a load pending: display clears and the load is lost.
        do_load(16'h89BC, 4'b1001);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("slot2 reset an", {28'd0, bus.an}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("slot2 reset restart seg", {24'd0, bus.seg}, 32'hC0);
        chk("slot2 reset restart an", {28'd0, bus.an}, 32'hE);
        wait_tick("pending lost");
        if (LZ) check_frame("pending lost", 32'hFFFFFFC0, 16'hFFFE);
        else    check_frame("pending lost", 32'hC0C0C0C0, 16'h7BDE);
        $display("seq reset-in-slot2 done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
